// File: rtl/switch_debouncer.sv
// Synchronises and debounces N_SW slide switches into CLK_50 and produces
// clean levels plus registered one-cycle rise/fall strobes per channel.
module switch_debouncer #(
  parameter int N_SW        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000
) (
  input  logic            CLK_50,
  input  logic            RST,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] SW_CLEAN,
  output logic [N_SW-1:0] SW_RISE,
  output logic [N_SW-1:0] SW_FALL,
  output logic            ANY_CHANGE
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {
    STABLE,
    COUNTING
  } db_state_t;

  logic [N_SW-1:0] sync_q [SYNC_STAGES];
  logic [N_SW-1:0] s;
  logic [N_SW-1:0] clean_nxt;
  logic [N_SW-1:0] rise_nxt;
  logic [N_SW-1:0] fall_nxt;

  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= SW;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Each channel owns its own counter; a level that falls back to the
  // accepted value before the count completes is treated as bounce.
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_d, rise_d, fall_d;

    always_ff @(posedge CLK_50 or posedge RST) begin
      if (RST) begin
        state_q <= STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = SW_CLEAN[i];
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        STABLE: begin
          cnt_d = '0;
          if (s[i] != SW_CLEAN[i]) begin
            state_d = COUNTING;
            cnt_d   = CW'(1);
          end
        end
        COUNTING: begin
          if (s[i] == SW_CLEAN[i]) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE;
            cnt_d   = '0;
            clean_d = s[i];
            rise_d  = s[i];
            fall_d  = ~s[i];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign clean_nxt[i] = clean_d;
    assign rise_nxt[i]  = rise_d;
    assign fall_nxt[i]  = fall_d;
  end

  // Strobes are registered alongside the clean level so they line up exactly.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      SW_CLEAN   <= '0;
      SW_RISE    <= '0;
      SW_FALL    <= '0;
      ANY_CHANGE <= 1'b0;
    end else begin
      SW_CLEAN   <= clean_nxt;
      SW_RISE    <= rise_nxt;
      SW_FALL    <= fall_nxt;
      ANY_CHANGE <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: a sample-window reference model
// checked every cycle, plus directed vectors with hand-computed expectations.
module tb_switch_debouncer;

  localparam int N_SW = 4;
  localparam int SS   = 2;
  localparam int DB   = 8;
  localparam int HL   = SS + DB;

  logic            clk;
  logic            rst;
  logic [N_SW-1:0] sw;
  logic [N_SW-1:0] sw_clean;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            any_change;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  logic burst_phase = 1'b0;

  switch_debouncer #(
    .N_SW(N_SW),
    .SYNC_STAGES(SS),
    .DB_CYCLES(DB)
  ) dut (
    .CLK_50(clk),
    .RST(rst),
    .SW(sw),
    .SW_CLEAN(sw_clean),
    .SW_RISE(sw_rise),
    .SW_FALL(sw_fall),
    .ANY_CHANGE(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: hist[k] is SW as sampled k edges ago. A channel's clean level
  // flips when the DB samples seen through the synchroniser all agree on the
  // opposite value.
  logic [N_SW-1:0] hist [HL];
  logic [N_SW-1:0] m_clean, m_rise, m_fall;
  logic            m_any;
  logic            agree;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
    end else begin
      for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw;
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < N_SW; ch++) begin
        agree = 1'b1;
        for (int j = SS; j < HL; j++) begin
          if (hist[j][ch] != hist[SS][ch]) agree = 1'b0;
        end
        if (agree && hist[SS][ch] != m_clean[ch]) begin
          m_clean[ch] = hist[SS][ch];
          if (hist[SS][ch]) m_rise[ch] = 1'b1;
          else              m_fall[ch] = 1'b1;
        end
      end
      m_any = |(m_rise | m_fall);
    end
  end

  task automatic checkOutput(input string name, input logic [N_SW-1:0] act,
                             input logic [N_SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      checkOutput("model_clean", sw_clean, m_clean);
      checkOutput("model_rise", sw_rise, m_rise);
      checkOutput("model_fall", sw_fall, m_fall);
      checkOutput("model_any", {3'b0, any_change}, {3'b0, m_any});
    end
  end

  always @(posedge clk) begin
    #1;
    if (burst_phase) strobe_cnt += $countones(sw_rise | sw_fall);
  end

  task automatic applyStimulus(input logic [N_SW-1:0] val);
    @(negedge clk);
    sw = val;
  endtask

  task automatic edgeCheck(input string tag, input logic [N_SW-1:0] c,
                           input logic [N_SW-1:0] r, input logic [N_SW-1:0] f,
                           input logic a);
    @(posedge clk);
    #1;
    checkOutput({tag, "_clean"}, sw_clean, c);
    checkOutput({tag, "_rise"}, sw_rise, r);
    checkOutput({tag, "_fall"}, sw_fall, f);
    checkOutput({tag, "_any"}, {3'b0, any_change}, {3'b0, a});
  endtask

  int run_left [N_SW];
  logic [N_SW-1:0] lvl;

  initial begin
    rst = 1'b1;
    sw  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_clean", sw_clean, 4'h0);
    checkOutput("reset_strobes", sw_rise | sw_fall, 4'h0);
    checkOutput("reset_any", {3'b0, any_change}, 4'h0);

    // Switches held high through reset rise together after SS+DB edges.
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) edgeCheck("t1_wait", 4'h0, 4'h0, 4'h0, 1'b0);
    edgeCheck("t1_edge10", 4'hF, 4'hF, 4'h0, 1'b1);
    edgeCheck("t1_after", 4'hF, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'h0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t2_base", sw_clean, 4'h0);

    // Short pulse on SW[0] is bounce; the later steady high is accepted.
    applyStimulus(4'h1);
    for (int e = 1; e <= 5; e++) edgeCheck("t2_pulse", 4'h0, 4'h0, 4'h0, 1'b0);
    applyStimulus(4'h0);
    for (int e = 1; e <= 5; e++) edgeCheck("t2_gap", 4'h0, 4'h0, 4'h0, 1'b0);
    applyStimulus(4'h1);
    for (int e = 1; e <= 9; e++) edgeCheck("t2_hold", 4'h0, 4'h0, 4'h0, 1'b0);
    edgeCheck("t2_edge10", 4'h1, 4'h1, 4'h0, 1'b1);

    applyStimulus(4'h4);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t3_base", sw_clean, 4'h4);
    applyStimulus(4'h0);
    for (int e = 1; e <= 9; e++) edgeCheck("t3_wait", 4'h4, 4'h0, 4'h0, 1'b0);
    edgeCheck("t3_edge10", 4'h0, 4'h0, 4'h4, 1'b1);
    edgeCheck("t3_after", 4'h0, 4'h0, 4'h0, 1'b0);

    applyStimulus(4'hA);
    for (int e = 1; e <= 9; e++) edgeCheck("t4_wait", 4'h0, 4'h0, 4'h0, 1'b0);
    edgeCheck("t4_edge10", 4'hA, 4'hA, 4'h0, 1'b1);
    edgeCheck("t4_after", 4'hA, 4'h0, 4'h0, 1'b0);

    // Reset mid-count clears outputs at once and the count restarts.
    applyStimulus(4'hB);
    for (int e = 1; e <= 8; e++) edgeCheck("t5_count", 4'hA, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_clean", sw_clean, 4'h0);
    checkOutput("t5_async_strobes", sw_rise | sw_fall, 4'h0);
    checkOutput("t5_async_any", {3'b0, any_change}, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) edgeCheck("t5_wait", 4'h0, 4'h0, 4'h0, 1'b0);
    edgeCheck("t5_edge10", 4'hB, 4'hB, 4'h0, 1'b1);
    edgeCheck("t5_after", 4'hB, 4'h0, 4'h0, 1'b0);

    // Bounce bursts shorter than DB on every channel must never strobe.
    lvl = sw;
    for (int ch = 0; ch < N_SW; ch++) run_left[ch] = 0;
    burst_phase = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int ch = 0; ch < N_SW; ch++) begin
        if (run_left[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          run_left[ch] = $urandom_range(1, DB - 1);
        end
        run_left[ch]--;
      end
      applyStimulus(lvl);
    end
    repeat (4) @(posedge clk);
    burst_phase = 1'b0;
    #2;
    checkOutput("t6_strobe_count", strobe_cnt[3:0] | {3'b0, strobe_cnt > 15}, 4'h0);
    checkOutput("t6_clean_held", sw_clean, 4'hB);

    applyStimulus(4'h5);
    repeat (14) @(posedge clk);
    #3;
    checkOutput("final_clean", sw_clean, 4'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
